// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: pulls bytes from a TX FIFO and serialises start/data/parity/stop.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN (adds tx_break input).
module uart_tx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0
) (
  input  logic                 uart_clk,
  input  logic                 rst_n,
`ifdef UART_TX_BREAK_EN
  input  logic                 tx_break,
`endif
  input  logic                 tf_empty,
  input  logic [DATA_BITS-1:0] tf_data,
  output logic                 tf_rdreq,
  output logic                 uart_txd,
  output logic                 tx_busy,
  output logic                 frame_done
);

  if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || OVERSAMPLE > 64 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || PARITY < 0 || PARITY > 2) begin : g_param_check
    $error("uart_tx_frame: parameter out of legal range");
  end

  localparam int BW = $clog2(OVERSAMPLE);
  localparam logic [BW-1:0] BAUD_LAST = BW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(OVERSAMPLE - 2);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOAD, S_START, S_DATA, S_PAR, S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BRK
`endif
  } state_e;

  state_e                 state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   txd_q, txd_d;
  logic                   rdreq_q, rdreq_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   baud_tick;

  assign baud_tick = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    rdreq_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        baud_d = '0;
        bit_d  = '0;
`ifdef UART_TX_BREAK_EN
        if (tx_break) begin
          state_d = S_BRK;
          busy_d  = 1'b1;
          txd_d   = 1'b0;
        end else
`endif
        if (!tf_empty) begin
          state_d = S_READ;
          rdreq_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_READ: state_d = S_LOAD;
      S_LOAD: begin
        shift_d = tf_data;
        par_d   = (PARITY == 1) ? ~(^tf_data) : ^tf_data;
        txd_d   = 1'b0;
        baud_d  = '0;
        state_d = S_START;
      end
      S_START: begin
        baud_d = baud_tick ? '0 : baud_q + 1'b1;
        if (baud_tick) begin
          state_d = S_DATA;
          bit_d   = '0;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_DATA: begin
        baud_d = baud_tick ? '0 : baud_q + 1'b1;
        if (baud_tick) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PAR;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PAR: begin
        baud_d = baud_tick ? '0 : baud_q + 1'b1;
        if (baud_tick) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        baud_d = baud_tick ? '0 : baud_q + 1'b1;
        // Registered pulse: set one edge early so it is high in the final stop cycle.
        if (bit_q == STOP_LAST && baud_q == BAUD_PRE) done_d = 1'b1;
        if (baud_tick) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BRK: begin
        // Line low while break is requested, then one bit time of mark before IDLE.
        if (tx_break) begin
          txd_d  = 1'b0;
          baud_d = '0;
        end else if (!txd_q) begin
          txd_d  = 1'b1;
          baud_d = '0;
        end else begin
          baud_d = baud_tick ? '0 : baud_q + 1'b1;
          if (baud_tick) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge uart_clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      rdreq_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      rdreq_q <= rdreq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tf_rdreq   = rdreq_q;
  assign uart_txd   = txd_q;
  assign tx_busy    = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four parameter sets, FIFO model, frame-decoding monitor with expected queue.
// Define UART_TX_BREAK_EN to also exercise the line-break path.
module tb_uart_tx_frame;
  localparam int W = 10;  // {parity_bit, data[8:0]}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef UART_TX_BREAK_EN
  logic tx_break = 1'b0;
`endif

  logic [8:0] fifo[$];
  logic [W-1:0] exp_q[$];
  logic [8:0] tf_data_r = '0;
  logic tf_empty_r = 1'b1;
  logic rd_seen = 1'b0;
  logic [3:0] empty_w, rdreq_w, txd_w, busy_w, done_w;
  logic txd_m, busy_m, done_m, rdreq_m;
  int sel = 0;
  int os_m = 16, db_m = 8, sb_m = 1, par_m = 0;
  logic mon_en = 1'b1;
  int mon_cyc = 0, rd_cyc = -100, rd_cnt = 0;
  int checks = 0, errors = 0;

  always_comb begin
    for (int k = 0; k < 4; k++) empty_w[k] = (sel == k) ? tf_empty_r : 1'b1;
    txd_m   = txd_w[sel];
    busy_m  = busy_w[sel];
    done_m  = done_w[sel];
    rdreq_m = rdreq_w[sel];
  end

  // FIFO model: data appears the cycle after the read request.
  always @(negedge clk) begin
    tf_empty_r <= (fifo.size() == 0);
    rd_seen    <= rdreq_m;
  end
  always @(posedge clk) if (rd_seen && fifo.size() != 0) tf_data_r <= fifo.pop_front();

  uart_tx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY(0)) u_dut0 (
    .uart_clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .tx_break(tx_break),
`endif
    .tf_empty(empty_w[0]), .tf_data(tf_data_r[7:0]), .tf_rdreq(rdreq_w[0]),
    .uart_txd(txd_w[0]), .tx_busy(busy_w[0]), .frame_done(done_w[0]));
  uart_tx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY(1)) u_dut1 (
    .uart_clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .tx_break(tx_break),
`endif
    .tf_empty(empty_w[1]), .tf_data(tf_data_r[7:0]), .tf_rdreq(rdreq_w[1]),
    .uart_txd(txd_w[1]), .tx_busy(busy_w[1]), .frame_done(done_w[1]));
  uart_tx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY(2)) u_dut2 (
    .uart_clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .tx_break(tx_break),
`endif
    .tf_empty(empty_w[2]), .tf_data(tf_data_r[7:0]), .tf_rdreq(rdreq_w[2]),
    .uart_txd(txd_w[2]), .tx_busy(busy_w[2]), .frame_done(done_w[2]));
  uart_tx_frame #(.DATA_BITS(7), .OVERSAMPLE(8), .STOP_BITS(2), .PARITY(0)) u_dut3 (
    .uart_clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .tx_break(tx_break),
`endif
    .tf_empty(empty_w[3]), .tf_data(tf_data_r[6:0]), .tf_rdreq(rdreq_w[3]),
    .uart_txd(txd_w[3]), .tx_busy(busy_w[3]), .frame_done(done_w[3]));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic use_dut(input int k);
    sel = k;
    os_m = (k == 3) ? 8 : 16;
    db_m = (k == 3) ? 7 : 8;
    sb_m = (k == 3) ? 2 : 1;
    par_m = (k == 3) ? 0 : k;
  endtask

  task automatic send(input logic [8:0] d, input logic p);
    exp_q.push_back({p, d});
    fifo.push_back(d);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    int quiet = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge clk);
      n++;
      if (exp_q.size() == 0 && fifo.size() == 0 && !busy_m) quiet++;
      else quiet = 0;
    end
    check("drain_within_budget", quiet, 4);
  endtask

  task automatic mon_tick();
    @(negedge clk);
    mon_cyc++;
    if (rdreq_m) begin
      rd_cnt++;
      rd_cyc = mon_cyc;
    end
  endtask

  // Monitor: on each start-bit fall, pop the expected byte and check every cycle of the frame.
  initial begin : monitor
    logic prev;
    logic [W-1:0] e;
    logic [15:0] lv, mid;
    logic [8:0] dgot;
    int nbits, flen, done_at, done_n, bad_k;
    prev = 1'b1;
    forever begin
      mon_tick();
      if (mon_en && rst_n && prev && !txd_m) begin
        check("start_latency_after_rdreq", mon_cyc - rd_cyc, 2);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got a start bit, want none queued (t=%0t)", $time);
          e = '0;
        end else begin
          e = exp_q.pop_front();
        end
        nbits = 1 + db_m + ((par_m != 0) ? 1 : 0) + sb_m;
        lv = '1;
        lv[0] = 1'b0;
        for (int i = 0; i < db_m; i++) lv[1+i] = e[i];
        if (par_m != 0) lv[1+db_m] = e[9];
        flen = nbits * os_m;
        done_at = 0;
        done_n = 0;
        bad_k = 0;
        mid = '0;
        for (int k = 1; k <= flen; k++) begin
          if (k > 1) mon_tick();
          if (txd_m !== lv[(k-1)/os_m] && bad_k == 0) bad_k = k;
          if ((k - 1) % os_m == os_m / 2) mid[(k-1)/os_m] = txd_m;
          if (done_m) begin
            done_at = k;
            done_n++;
          end
        end
        dgot = '0;
        for (int i = 0; i < db_m; i++) dgot[i] = mid[1+i];
        check("data_decoded", dgot, e[8:0]);
        if (par_m != 0) check("parity_bit", mid[1+db_m], e[9]);
        check("first_bad_line_cycle", bad_k, 0);
        check("frame_done_cycle", done_at, flen);
        check("frame_done_pulses", done_n, 1);
        mon_tick();
        check("busy_low_after_frame", busy_m, 0);
      end
      prev = txd_m;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int r0, n;
    use_dut(0);
    repeat (3) @(negedge clk);
    check("reset_txd", txd_m, 1);
    check("reset_rdreq", rdreq_m, 0);
    check("reset_busy", busy_m, 0);
    check("reset_done", done_m, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    r0 = rd_cnt;
    send(9'h055, 1'b0);
    drain(1000);
    check("rdreq_pulses_55", rd_cnt - r0, 1);

    use_dut(1);
    send(9'h000, 1'b1);
    send(9'h007, 1'b0);
    drain(2000);
    use_dut(2);
    send(9'h007, 1'b1);
    send(9'h000, 1'b0);
    drain(2000);

    use_dut(3);
    send(9'h041, 1'b0);
    drain(1000);

    use_dut(0);
    r0 = rd_cnt;
    send(9'h0A3, 1'b0);
    send(9'h03C, 1'b0);
    drain(2000);
    check("rdreq_pulses_back_to_back", rd_cnt - r0, 2);

    // Reset in the middle of the 4th data bit of 0xFF.
    mon_en = 1'b0;
    fifo.push_back(9'h0FF);
    n = 0;
    while (txd_m && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("mid_reset_frame_started", txd_m, 0);
    repeat (4 * 16 + 8 - 1) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_reset_txd", txd_m, 1);
    check("mid_reset_busy", busy_m, 0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    send(9'h05A, 1'b0);
    drain(1000);

`ifdef UART_TX_BREAK_EN
    begin
      int lo, hi;
      mon_en = 1'b0;
      r0 = rd_cnt;
      lo = 0;
      hi = 0;
      tx_break = 1'b1;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (i == 0) fifo.push_back(9'h096);
        if (!txd_m) lo++;
      end
      tx_break = 1'b0;
      for (int i = 0; i < 200 && busy_m; i++) begin
        @(negedge clk);
        if (busy_m) begin
          if (!txd_m) lo++;
          else hi++;
        end
      end
      check("break_low_cycles", lo, 100);
      check("break_mark_cycles", hi, 16);
      check("break_no_rdreq", rd_cnt - r0, 0);
      mon_en = 1'b1;
      exp_q.push_back({1'b0, 9'h096});
      drain(1000);
    end
`endif

    check("exp_q_empty_at_end", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
